// File: rtl/inst_fetch_buf.sv
// Single-line instruction fetch buffer: serves 4-word line hits combinationally and
// refills the line from a ready/ack memory bus, words 0..3 in order, on a miss.
module inst_fetch_buf (
   input  logic        clk,
   input  logic        rst,
   input  logic        rom_ce_i,
   input  logic [31:0] rom_addr_i,
   output logic [31:0] rom_data_o,
   output logic        stall_req_o,
   input  logic        flush_i,
   output logic        bus_req_o,
   output logic [31:0] bus_addr_o,
   input  logic        bus_ack_i,
   input  logic [31:0] bus_rdata_i
);

   typedef enum logic {IDLE, FILL} state_t;

   state_t      state;
   logic [31:0] data [4];
   logic [27:0] tag;
   logic [27:0] fill_tag;
   logic        valid;
   logic        flush_pend;
   logic [1:0]  k;
   logic        hit;
   logic        unused_addr_bits;

   // Fetches are word-granular, so the byte offset never takes part in the lookup.
   assign unused_addr_bits = ^rom_addr_i[1:0];

   assign hit = (state == IDLE) && rom_ce_i && valid && (tag == rom_addr_i[31:4]);

   always_comb begin
      // NOTE: every output gets a default first, so no path through the block infers a latch.
      rom_data_o  = '0;
      stall_req_o = 1'b0;
      bus_req_o   = 1'b0;
      bus_addr_o  = '0;
      if (rst) begin
         if (state == FILL) begin
            stall_req_o = 1'b1;
            bus_req_o   = 1'b1;
            bus_addr_o  = {fill_tag, k, 2'b00};
         end else if (rom_ce_i) begin
            if (hit) rom_data_o  = data[rom_addr_i[3:2]];
            else     stall_req_o = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         // NOTE: the line storage is reset too, so a refill aborted by reset leaves no stale words behind.
         state      <= IDLE;
         valid      <= 1'b0;
         flush_pend <= 1'b0;
         k          <= 2'd0;
         tag        <= '0;
         fill_tag   <= '0;
         for (int i = 0; i < 4; i++) data[i] <= '0;
      end else begin
         // NOTE: sequential state uses non-blocking assignments; later ones in the block win.
         case (state)
            IDLE: begin
               if (flush_i) valid <= 1'b0;
               if (rom_ce_i && !hit) begin
                  state      <= FILL;
                  fill_tag   <= rom_addr_i[31:4];
                  k          <= 2'd0;
                  valid      <= 1'b0;
                  flush_pend <= 1'b0;
               end
            end
            FILL: begin
               if (flush_i) flush_pend <= 1'b1;
               if (bus_ack_i) begin
                  data[k] <= bus_rdata_i;
                  k       <= k + 2'd1;
                  if (k == 2'd3) begin
                     // A flush seen at any point of the refill, including this edge, keeps the line invalid.
                     state      <= IDLE;
                     tag        <= fill_tag;
                     valid      <= !(flush_pend || flush_i);
                     flush_pend <= 1'b0;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/inst_fetch_buf.md
INST_FETCH_BUF -- requirements
Module: inst_fetch_buf

Interface
REQ-001 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-002 SHALL have port rst, input, 1, asynchronous active-low reset (0 = reset asserted).
REQ-003 SHALL have port rom_ce_i, input, 1, fetch enable from pc_reg.
REQ-004 SHALL have port rom_addr_i, input, 32, byte address of the instruction (pc).
REQ-005 SHALL have port rom_data_o, output, 32, instruction returned to if_id.
REQ-006 SHALL have port stall_req_o, output, 1, the pipeline holds pc and if_id while high.
REQ-007 SHALL have port flush_i, input, 1, invalidate the line buffer.
REQ-008 SHALL have port bus_req_o, output, 1, memory read request.
REQ-009 SHALL have port bus_addr_o, output, 32, word-aligned read address.
REQ-010 SHALL have port bus_ack_i, input, 1, read data valid and beat accepted.
REQ-011 SHALL have port bus_rdata_i, input, 32, read data.

Function
REQ-012 SHALL hold one 4-word line: data[0..3] x32, tag x28 (addr[31:4]), valid x1.
REQ-013 Hit SHALL be defined as rom_ce_i=1, valid=1 and tag==rom_addr_i[31:4]; rom_addr_i[1:0] is ignored.
REQ-014 On hit, rom_data_o SHALL be data[rom_addr_i[3:2]] combinationally, with stall_req_o=0 in the same cycle.
REQ-015 When rom_ce_i=0, the block SHALL drive rom_data_o=0 and stall_req_o=0, and SHALL start no fetch.
REQ-016 On miss, stall_req_o SHALL be 1 combinationally and rom_data_o SHALL be 0.
REQ-017 The FSM SHALL have two states, IDLE and FILL.
REQ-018 IDLE->FILL transition: on a clock edge with a miss, latch fill_tag=rom_addr_i[31:4] and set beat counter k=0.
REQ-019 In FILL, the block SHALL drive bus_req_o=1, bus_addr_o={fill_tag,k[1:0],2'b00} and stall_req_o=1 regardless of rom_addr_i.
REQ-020 Outside FILL, bus_req_o SHALL be 0 and bus_addr_o SHALL be 0.
REQ-021 bus_req_o and bus_addr_o SHALL stay stable until a rising edge samples bus_ack_i=1; wait states are unlimited.
REQ-022 On an acked beat, the block SHALL write data[k]=bus_rdata_i and then increment k (2-bit, wrapping).
REQ-023 On the ack of beat k=3, the block SHALL set tag=fill_tag and valid=1 (unless REQ-025 applies) and return to IDLE.
REQ-024 Fill order SHALL be fixed at words 0,1,2,3; there is no critical-word-first.
REQ-025 flush_i in IDLE SHALL clear valid at the next edge; flush_i in FILL SHALL set flush_pend, the fill SHALL complete, valid SHALL stay 0, and flush_pend SHALL clear on the return to IDLE.
REQ-026 If flush_i and a miss occur on the same IDLE edge, the FILL transition SHALL proceed and valid SHALL be cleared.
REQ-027 bus_ack_i SHALL be ignored outside FILL.
REQ-028 A rom_addr_i change during FILL SHALL NOT alter the fill in progress; the new address is evaluated in IDLE afterwards.
REQ-029 With a zero-wait bus, miss penalty SHALL be 5 cycles of stall_req_o=1 (1 IDLE plus 4 FILL), followed by a hit.

Reset
REQ-030 While rst=0, the block SHALL immediately force state=IDLE, valid=0, flush_pend=0, k=0, tag=0, and data[0..3]=0.
REQ-031 Under reset, the outputs SHALL be rom_data_o=0, stall_req_o=0, bus_req_o=0 and bus_addr_o=0.
REQ-032 rst asserted mid-FILL SHALL abort the fill with no partial validation; after release, the first access SHALL miss.

Verification
REQ-033 Cold miss, zero-wait bus: rom_addr_i=0x100 with ack always 1 -> bus_addr_o sequence 0x100, 0x104, 0x108, 0x10C; stall high for 5 cycles; then rom_data_o=word read at 0x100.
REQ-034 Sequential hits: after the fill of 0x100, addresses 0x104, 0x108, 0x10C -> stall 0 and the correct word each cycle, with no bus_req_o.
REQ-035 Wait states: ack is delayed 3 cycles per beat -> bus_addr_o is held stable, each beat is written once, and stall lasts 1+16 cycles.
REQ-036 Flush mid-fill: flush_i is pulsed in beat 1 -> the fill completes, and the same address then misses again and refetches from 0x100.
REQ-037 Reset mid-fill: rst=0 during beat 2 -> bus_req_o=0 immediately; after release, the access to 0x100 misses with k starting at 0.
REQ-038 rom_ce_i=0 with any address -> rom_data_o=0, stall 0, and no bus activity.
